// File: rtl/seq_detect_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : seq_detect_ctrl
// Description : Windowed, programmable serial pattern detector with a run
//               controller (config handshake, start/abort, done pulse).
//               SEQ_DETECT_OVERLAP_EN: when defined, overlapping matches count.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_detect_ctrl #(
    parameter int               PAT_W       = 5,
    parameter logic [PAT_W-1:0] DEF_PATTERN = 5'b00110,
    parameter int               WIN_W       = 8,
    parameter int               CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [WIN_W-1:0] cfg_window,
    input  logic             start,
    input  logic             abort,
    input  logic             bit_valid,
    input  logic             w,
    output logic             busy,
    output logic             hit,
    output logic [CNT_W-1:0] match_count,
    output logic             done
);

    localparam int               FILL_W     = $clog2(PAT_W);
    localparam logic [FILL_W-1:0] C_FILL_MAX = FILL_W'(PAT_W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state,     w_state_nxt;
    logic [PAT_W-1:0]   r_pattern,   w_pattern_nxt;
    logic [WIN_W-1:0]   r_window,    w_window_nxt;
    logic [PAT_W-2:0]   r_history,   w_history_nxt;
    logic [FILL_W-1:0]  r_fill,      w_fill_nxt;
    logic [WIN_W-1:0]   r_remaining, w_remaining_nxt;
    logic [CNT_W-1:0]   r_count,     w_count_nxt;
    logic               r_hit,       w_hit_nxt;
    logic               r_done,      w_done_nxt;

    // Previous PAT_W-1 bits plus the current bit form the candidate word.
    logic [PAT_W-1:0]   w_shift;
    logic [WIN_W-1:0]   w_start_win;
    logic               w_match;

    assign w_shift     = {r_history, w};
    assign w_start_win = cfg_valid ? cfg_window : r_window;
    assign w_match     = bit_valid && (r_fill == C_FILL_MAX) && (w_shift == r_pattern);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_pattern_nxt   = r_pattern;
        w_window_nxt    = r_window;
        w_history_nxt   = r_history;
        w_fill_nxt      = r_fill;
        w_remaining_nxt = r_remaining;
        w_count_nxt     = r_count;
        w_hit_nxt       = 1'b0;
        w_done_nxt      = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (cfg_valid) begin
                    w_pattern_nxt = cfg_pattern;
                    w_window_nxt  = cfg_window;
                end
                if (start) begin
                    w_count_nxt     = '0;
                    w_history_nxt   = '0;
                    w_fill_nxt      = '0;
                    w_remaining_nxt = w_start_win;
                    if (w_start_win != '0) begin
                        w_state_nxt = S_RUN;
                    end else begin
                        // Empty window: finish without ever entering RUN.
                        w_state_nxt = S_DONE;
                        w_done_nxt  = 1'b1;
                    end
                end
            end

            S_RUN: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else if (bit_valid) begin
                    w_history_nxt   = w_shift[PAT_W-2:0];
                    w_fill_nxt      = (r_fill == C_FILL_MAX) ? r_fill : r_fill + FILL_W'(1);
                    w_remaining_nxt = r_remaining - WIN_W'(1);
                    if (w_match) begin
                        w_hit_nxt   = 1'b1;
                        w_count_nxt = (r_count == '1) ? r_count : r_count + CNT_W'(1);
`ifdef SEQ_DETECT_OVERLAP_EN
`else
                        w_history_nxt = '0;
                        w_fill_nxt    = '0;
`endif
                    end
                    if (r_remaining == WIN_W'(1)) begin
                        w_state_nxt = S_DONE;
                        w_done_nxt  = 1'b1;
                    end
                end
            end

            S_DONE: begin
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pattern   <= DEF_PATTERN;
            r_window    <= '0;
            r_history   <= '0;
            r_fill      <= '0;
            r_remaining <= '0;
            r_count     <= '0;
            r_hit       <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_pattern   <= w_pattern_nxt;
            r_window    <= w_window_nxt;
            r_history   <= w_history_nxt;
            r_fill      <= w_fill_nxt;
            r_remaining <= w_remaining_nxt;
            r_count     <= w_count_nxt;
            r_hit       <= w_hit_nxt;
            r_done      <= w_done_nxt;
        end
    end

    assign cfg_ready   = (r_state == S_IDLE);
    assign busy        = (r_state == S_RUN);
    assign hit         = r_hit;
    assign done        = r_done;
    assign match_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_seq_detect_ctrl.sv
`default_nettype none
// Testbench for seq_detect_ctrl: vector table for the default run plus
// directed sequences for overlap, gated bits, empty window, abort and reset.
module tb_seq_detect_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cfg_valid, cfg_ready, start, abort, bit_valid, w;
    logic [4:0] cfg_pattern;
    logic [7:0] cfg_window;
    logic       busy, hit, done;
    logic [7:0] match_count;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef SEQ_DETECT_OVERLAP_EN
    localparam int EXP_OVL = 2;
`else
    localparam int EXP_OVL = 1;
`endif

    seq_detect_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_pattern (cfg_pattern),
        .cfg_window  (cfg_window),
        .start       (start),
        .abort       (abort),
        .bit_valid   (bit_valid),
        .w           (w),
        .busy        (busy),
        .hit         (hit),
        .match_count (match_count),
        .done        (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       cv;
        logic [4:0] pat;
        logic [7:0] win;
        logic       st;
        logic       ab;
        logic       bv;
        logic       wi;
        logic       e_busy;
        logic       e_hit;
        logic       e_done;
        logic       e_rdy;
        logic [7:0] e_cnt;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic eb, input logic eh,
                           input logic ed, input logic er, input logic [7:0] ec);
        chk({tag, " busy"},        {7'd0, busy},      {7'd0, eb});
        chk({tag, " hit"},         {7'd0, hit},       {7'd0, eh});
        chk({tag, " done"},        {7'd0, done},      {7'd0, ed});
        chk({tag, " cfg_ready"},   {7'd0, cfg_ready}, {7'd0, er});
        chk({tag, " match_count"}, match_count,       ec);
    endtask

    task automatic drv(input logic cv, input logic [4:0] p, input logic [7:0] wn,
                       input logic st, input logic ab, input logic bv, input logic wi);
        cfg_valid   = cv;
        cfg_pattern = p;
        cfg_window  = wn;
        start       = st;
        abort       = ab;
        bit_valid   = bv;
        w           = wi;
    endtask

    task automatic idle();
        drv(1'b0, 5'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_table(input string tag);
        for (int i = 0; i < 12; i++) begin
            drv(tbl[i].cv, tbl[i].pat, tbl[i].win, tbl[i].st, tbl[i].ab, tbl[i].bv, tbl[i].wi);
            tick();
            chk_all($sformatf("%s row%0d", tag, i), tbl[i].e_busy, tbl[i].e_hit,
                    tbl[i].e_done, tbl[i].e_rdy, tbl[i].e_cnt);
        end
    endtask

    initial begin
        logic [9:0] s10;
        logic [6:0] s7;
        logic [5:0] s6;
        logic       b;

        // Default pattern 00110, window 10, stream 0011000110.
        //            cv    pat       win    st    ab    bv    w     busy  hit   done  rdy   cnt
        tbl[0]  = '{1'b1, 5'b00110, 8'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[1]  = '{1'b0, 5'b00000, 8'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[2]  = '{1'b0, 5'b00000, 8'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[3]  = '{1'b0, 5'b00000, 8'd0,  1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[4]  = '{1'b0, 5'b00000, 8'd0,  1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[5]  = '{1'b0, 5'b00000, 8'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1};
        tbl[6]  = '{1'b0, 5'b00000, 8'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1};
        tbl[7]  = '{1'b0, 5'b00000, 8'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1};
        tbl[8]  = '{1'b0, 5'b00000, 8'd0,  1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1};
        tbl[9]  = '{1'b0, 5'b00000, 8'd0,  1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1};
        tbl[10] = '{1'b0, 5'b00000, 8'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd2};
        tbl[11] = '{1'b0, 5'b00000, 8'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd2};

        idle();
        reset = 1'b1;
        tick();
        tick();
        chk_all("reset held", 1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
        reset = 1'b0;
        tick();
        chk_all("reset released", 1'b0, 1'b0, 1'b0, 1'b1, 8'd0);

        // Main default run.
        run_table("default");

        // Configure 01010 and start together; overlap decides the count.
        s7 = 7'b0101010;
        drv(1'b1, 5'b01010, 8'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        chk_all("ovl start", 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        for (int k = 1; k <= 7; k++) begin
            drv(1'b0, 5'd0, 8'd0, 1'b0, 1'b0, 1'b1, s7[7-k]);
            tick();
            chk($sformatf("ovl bit%0d done", k), {7'd0, done}, (k == 7) ? 8'd1 : 8'd0);
            chk($sformatf("ovl bit%0d hit", k), {7'd0, hit},
                (k == 5 || (k == 7 && EXP_OVL == 2)) ? 8'd1 : 8'd0);
        end
        chk("ovl final count", match_count, 8'(EXP_OVL));
        idle();
        tick();
        chk_all("ovl idle", 1'b0, 1'b0, 1'b0, 1'b1, 8'(EXP_OVL));

        // Stored window 6, bit_valid every other cycle, unqualified w inverted.
        s6 = 6'b100110;
        drv(1'b1, 5'b00110, 8'd6, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk_all("gated cfg", 1'b0, 1'b0, 1'b0, 1'b1, 8'(EXP_OVL));
        drv(1'b0, 5'd0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        chk_all("gated start", 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        for (int k = 1; k <= 12; k++) begin
            b = s6[5 - ((k - 1) / 2)];
            if ((k % 2) == 1) drv(1'b0, 5'd0, 8'd0, 1'b0, 1'b0, 1'b1, b);
            else              drv(1'b0, 5'd0, 8'd0, 1'b0, 1'b0, 1'b0, ~b);
            tick();
            chk_all($sformatf("gated cyc%0d", k), k < 11, k == 11, k == 11, k == 12,
                    (k >= 11) ? 8'd1 : 8'd0);
        end

        // Empty window.
        drv(1'b1, 5'b00110, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        chk_all("win0 start", 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
        idle();
        tick();
        chk_all("win0 after", 1'b0, 1'b0, 1'b0, 1'b1, 8'd0);

        // Abort two bits before end; cfg/start mid-run must be ignored.
        s10 = 10'b0011000110;
        drv(1'b1, 5'b00110, 8'd10, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        for (int k = 1; k <= 8; k++) begin
            drv(k == 7, 5'b11111, 8'd3, k == 7, 1'b0, 1'b1, s10[10-k]);
            tick();
            chk_all($sformatf("abort bit%0d", k), 1'b1, k == 5, 1'b0, 1'b0,
                    (k >= 5) ? 8'd1 : 8'd0);
        end
        drv(1'b0, 5'd0, 8'd0, 1'b0, 1'b1, 1'b1, 1'b1);
        tick();
        chk_all("abort edge", 1'b0, 1'b0, 1'b0, 1'b1, 8'd1);
        idle();
        tick();
        chk_all("abort after", 1'b0, 1'b0, 1'b0, 1'b1, 8'd1);
        drv(1'b0, 5'd0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        chk_all("rerun start", 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        for (int k = 1; k <= 10; k++) begin
            drv(1'b0, 5'd0, 8'd0, 1'b0, 1'b0, 1'b1, s10[10-k]);
            tick();
            chk_all($sformatf("rerun bit%0d", k), k < 10, (k == 5 || k == 10), k == 10,
                    1'b0, (k >= 10) ? 8'd2 : ((k >= 5) ? 8'd1 : 8'd0));
        end
        idle();
        tick();

        // Asynchronous reset in the middle of a run.
        drv(1'b1, 5'b01010, 8'd10, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        for (int k = 1; k <= 5; k++) begin
            drv(1'b0, 5'd0, 8'd0, 1'b0, 1'b0, 1'b1, s7[7-k]);
            tick();
        end
        chk_all("pre-reset", 1'b1, 1'b1, 1'b0, 1'b0, 8'd1);
        #3;
        reset = 1'b1;
        #1;
        chk_all("async reset", 1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
        idle();
        @(posedge clk);
        #1;
        reset = 1'b0;
        // Window register must be back to zero: stored-window start ends at once.
        drv(1'b0, 5'd0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        chk_all("post-reset win0", 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
        idle();
        tick();
        run_table("post-reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
